// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux_nto1: packed input channels with select,
// valid/ready on both sides, and a squash input.
interface pipe_mux_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
);
   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [NUM_IN*WIDTH-1:0] IN;
   logic [SEL_W-1:0]        SELECT;
   logic                    IN_VALID;
   logic                    IN_READY;
   logic                    FLUSH;
   logic [WIDTH-1:0]        OUT;
   logic                    OUT_VALID;
   logic                    OUT_READY;

   modport master (
      output IN, SELECT, IN_VALID, FLUSH, OUT_READY,
      input  IN_READY, OUT, OUT_VALID
   );

   modport slave (
      input  IN, SELECT, IN_VALID, FLUSH, OUT_READY,
      output IN_READY, OUT, OUT_VALID
   );
endinterface

// File: rtl/pipe_mux_nto1.sv
// Registered N-to-1 mux stage with valid/ready handshake and flush.
// Define PIPE_MUX_SKID_EN to add a skid register and a registered IN_READY.
module pipe_mux_nto1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
) (
   input logic       CLK,
   input logic       RESET,
   pipe_mux_if.slave bus
);
   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

`ifdef PIPE_MUX_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
   logic [WIDTH-1:0] skid_q;
`else
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

   state_t           state, state_nx;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] out_q;
   logic             ready;
   logic             accept;
   logic             drain;

   // Out-of-range selects match no channel and therefore yield zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++)
         if (bus.SELECT == SEL_W'(i)) sel_data = bus.IN[i*WIDTH +: WIDTH];
   end

   assign accept = bus.IN_VALID && ready;
   assign drain  = (state != EMPTY) && bus.OUT_READY;

   always_ff @(posedge CLK) begin
      if (RESET) state <= EMPTY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.FLUSH) begin
         state_nx = EMPTY;
      end else begin
`ifdef PIPE_MUX_SKID_EN
         case (state)
            EMPTY: if (accept) state_nx = FULL;
            FULL: begin
               if (accept && !drain)      state_nx = SKID;
               else if (!accept && drain) state_nx = EMPTY;
            end
            SKID:    if (drain) state_nx = FULL;
            default: state_nx = EMPTY;
         endcase
`else
         if (state == EMPTY && accept)                state_nx = FULL;
         else if (state == FULL && drain && !accept)  state_nx = EMPTY;
`endif
      end
   end

   always_comb begin
      ready = 1'b0;
      if (!RESET) begin
`ifdef PIPE_MUX_SKID_EN
         ready = (state != SKID);
`else
         ready = (state == EMPTY) || bus.OUT_READY;
`endif
      end
   end

   // Data path; a flush leaves stale data in place since OUT_VALID masks it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_q  <= '0;
`ifdef PIPE_MUX_SKID_EN
         skid_q <= '0;
`endif
      end else if (!bus.FLUSH) begin
`ifdef PIPE_MUX_SKID_EN
         case (state)
            EMPTY: if (accept) out_q <= sel_data;
            FULL: begin
               if (accept && drain) out_q  <= sel_data;
               else if (accept)     skid_q <= sel_data;
            end
            SKID:    if (drain) out_q <= skid_q;
            default: ;
         endcase
`else
         if (accept) out_q <= sel_data;
`endif
      end
   end

   assign bus.IN_READY  = ready;
   assign bus.OUT       = out_q;
   assign bus.OUT_VALID = (state != EMPTY);
endmodule
